// File: rtl/sid_waveform_mixer.sv
// ============================================================================
//  Module      : sid_waveform_mixer
//  Description : Combines per-voice waveform components into the 12-bit DAC
//                value, models the floating output, OSC3 readback and noise
//                LFSR writeback.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sid_waveform_mixer #(
    parameter logic [12:0] FLOAT_TTL_6581 = 13'd182,
    parameter logic [12:0] FLOAT_TTL_8580 = 13'd4400
) (
    input  logic        clk,
    input  logic        res_n,
    input  logic        tick_ms,
    input  logic        model,
    input  logic        stb,
    input  logic [3:0]  selector,
    input  logic [7:0]  noise,
    input  logic        pulse,
    input  logic [11:0] saw_tri,
    output logic [11:0] wav,
    output logic        wav_valid,
    output logic [7:0]  osc3,
    output logic [7:0]  noise_wb,
    output logic        noise_wb_en
);

    localparam logic [12:0] c_AGE_MAX = 13'h1fff;

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_HOLD   = 2'd1,
        ST_FADED  = 2'd2
    } state_t;

    state_t      r_state;
    logic [11:0] r_wav;
    logic        r_wav_valid;
    logic [7:0]  r_osc3;
    logic [7:0]  r_noise_wb;
    logic        r_noise_wb_en;
    logic [12:0] r_float_age;

    logic [11:0] w_noise_ext;
    logic [11:0] w_pulse_ext;
    logic [11:0] w_comb;
    logic [12:0] w_ttl;
    logic [12:0] w_age_next;
    logic        w_expired;
    logic        w_wb_en;

    assign w_noise_ext = {noise, 4'b0000};
    assign w_pulse_ext = {12{pulse}};

    // Unselected components contribute all-ones so they drop out of the AND;
    // saw and triangle share one input and enter the AND once.
    assign w_comb = (selector[3]                 ? w_noise_ext : 12'hfff)
                  & (selector[2]                 ? w_pulse_ext : 12'hfff)
                  & ((selector[1] | selector[0]) ? saw_tri     : 12'hfff);

    assign w_ttl      = model ? FLOAT_TTL_8580 : FLOAT_TTL_6581;
    assign w_age_next = (r_float_age == c_AGE_MAX) ? r_float_age
                                                   : r_float_age + {12'd0, tick_ms};
    // Compare against the age including this tick, re-evaluated on every stb
    // so a model change during a hold applies immediately.
    assign w_expired  = (w_age_next >= w_ttl);
    assign w_wb_en    = selector[3] & (|selector[2:0]);

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            r_state       <= ST_ACTIVE;
            r_wav         <= 12'h000;
            r_wav_valid   <= 1'b0;
            r_osc3        <= 8'h00;
            r_noise_wb    <= 8'hff;
            r_noise_wb_en <= 1'b0;
            r_float_age   <= 13'd0;
        end else begin
            r_wav_valid <= stb;
            if (stb) begin
                r_noise_wb_en <= w_wb_en;
                r_noise_wb    <= w_wb_en ? w_comb[11:4] : 8'hff;
                if (selector != 4'd0) begin
                    r_wav       <= w_comb;
                    r_osc3      <= w_comb[11:4];
                    r_float_age <= 13'd0;
                    r_state     <= ST_ACTIVE;
                end else begin
                    r_float_age <= w_age_next;
                    if (w_expired || (r_state == ST_FADED)) begin
                        r_wav   <= 12'h000;
                        r_osc3  <= 8'h00;
                        r_state <= ST_FADED;
                    end else begin
                        r_state <= ST_HOLD;
                    end
                end
            end
        end
    end

    assign wav         = r_wav;
    assign wav_valid   = r_wav_valid;
    assign osc3        = r_osc3;
    assign noise_wb    = r_noise_wb;
    assign noise_wb_en = r_noise_wb_en;

endmodule

`default_nettype wire

// File: tb/tb_sid_waveform_mixer.sv
// ============================================================================
//  Module      : tb_sid_waveform_mixer
//  Description : Directed self-checking bench for sid_waveform_mixer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sid_waveform_mixer;

    logic        clk;
    logic        res_n;
    logic        tick_ms;
    logic        model;
    logic        stb;
    logic [3:0]  selector;
    logic [7:0]  noise;
    logic        pulse;
    logic [11:0] saw_tri;
    logic [11:0] wav;
    logic        wav_valid;
    logic [7:0]  osc3;
    logic [7:0]  noise_wb;
    logic        noise_wb_en;

    int n_tests = 0;
    int n_fail  = 0;

    sid_waveform_mixer dut (
        .clk         (clk),
        .res_n       (res_n),
        .tick_ms     (tick_ms),
        .model       (model),
        .stb         (stb),
        .selector    (selector),
        .noise       (noise),
        .pulse       (pulse),
        .saw_tri     (saw_tri),
        .wav         (wav),
        .wav_valid   (wav_valid),
        .osc3        (osc3),
        .noise_wb    (noise_wb),
        .noise_wb_en (noise_wb_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One stb cycle; returns 1 time unit after the sampling edge.
    task automatic do_stb(input logic [3:0] sel, input logic [7:0] nz, input logic pl,
                          input logic [11:0] st, input logic tk);
        @(negedge clk);
        selector = sel; noise = nz; pulse = pl; saw_tri = st; tick_ms = tk; stb = 1'b1;
        @(posedge clk);
        #1;
        stb = 1'b0; tick_ms = 1'b0;
    endtask

    // n back-to-back floating stb cycles, each carrying a millisecond tick.
    task automatic float_run(input int n);
        @(negedge clk);
        selector = 4'd0; stb = 1'b1; tick_ms = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        stb = 1'b0; tick_ms = 1'b0;
    endtask

    initial begin
        res_n = 1'b0; tick_ms = 1'b0; model = 1'b0; stb = 1'b0;
        selector = 4'd0; noise = 8'h00; pulse = 1'b0; saw_tri = 12'h000;
        repeat (3) @(posedge clk);
        #1;
        check("rst_wav",       wav,         12'h000);
        check("rst_valid",     wav_valid,   1'b0);
        check("rst_osc3",      osc3,        8'h00);
        check("rst_noise_wb",  noise_wb,    8'hff);
        check("rst_wb_en",     noise_wb_en, 1'b0);
        @(negedge clk);
        res_n = 1'b1;

        // Sawtooth only
        do_stb(4'b0010, 8'h00, 1'b0, 12'hABC, 1'b0);
        check("saw_wav",   wav,         12'hABC);
        check("saw_osc3",  osc3,        8'hAB);
        check("saw_valid", wav_valid,   1'b1);
        check("saw_wb_en", noise_wb_en, 1'b0);
        check("saw_wb",    noise_wb,    8'hff);
        @(posedge clk); #1;
        check("valid_drop", wav_valid, 1'b0);

        // Pulse & saw
        do_stb(4'b0110, 8'h00, 1'b1, 12'h5A5, 1'b0);
        check("ps_hi_wav", wav, 12'h5A5);
        do_stb(4'b0110, 8'h00, 1'b0, 12'h5A5, 1'b0);
        check("ps_lo_wav", wav, 12'h000);

        // Noise & saw with writeback
        do_stb(4'b1010, 8'hF0, 1'b0, 12'hCCC, 1'b0);
        check("ns_wav",   wav,         12'hC00);
        check("ns_osc3",  osc3,        8'hC0);
        check("ns_wb",    noise_wb,    8'hC0);
        check("ns_wb_en", noise_wb_en, 1'b1);

        // 6581 float hold: 181 ticks held, gone on tick 182
        model = 1'b0;
        do_stb(4'b0010, 8'h00, 1'b0, 12'h800, 1'b0);
        float_run(181);
        check("f6581_hold",  wav,         12'h800);
        check("f6581_b2b",   wav_valid,   1'b1);
        check("f6581_wb_en", noise_wb_en, 1'b0);
        check("f6581_wb",    noise_wb,    8'hff);
        float_run(1);
        check("f6581_fade_wav",  wav,  12'h000);
        check("f6581_fade_osc3", osc3, 8'h00);

        // 8580 float hold: 4399 ticks held, gone on tick 4400
        model = 1'b1;
        do_stb(4'b0010, 8'h00, 1'b0, 12'h800, 1'b0);
        check("f8580_osc3_pre", osc3, 8'h80);
        float_run(4399);
        check("f8580_hold", wav, 12'h800);
        float_run(1);
        check("f8580_fade", wav, 12'h000);

        // Model change mid-hold takes effect on the next stb
        do_stb(4'b0010, 8'h00, 1'b0, 12'h800, 1'b0);
        float_run(500);
        check("mchg_hold", wav, 12'h800);
        model = 1'b0;
        do_stb(4'b0000, 8'h00, 1'b0, 12'h000, 1'b0);
        check("mchg_fade", wav, 12'h000);
        do_stb(4'b0001, 8'h00, 1'b0, 12'h123, 1'b0);
        check("tri_wav", wav, 12'h123);
        // Age was cleared: a fresh 181-tick hold must not fade
        float_run(181);
        check("age_clr_hold", wav, 12'h123);
        float_run(1);
        check("age_clr_fade", wav, 12'h000);

        // Asynchronous reset during a hold
        do_stb(4'b0011, 8'h00, 1'b0, 12'h777, 1'b0);
        do_stb(4'b0000, 8'h00, 1'b0, 12'h000, 1'b1);
        check("pre_rst_wav",   wav,       12'h777);
        check("pre_rst_valid", wav_valid, 1'b1);
        #1;
        res_n = 1'b0;
        #1;
        check("arst_wav",   wav,       12'h000);
        check("arst_osc3",  osc3,      8'h00);
        check("arst_valid", wav_valid, 1'b0);
        check("arst_wb",    noise_wb,  8'hff);
        @(negedge clk);
        res_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/sid_waveform_mixer.md
Name: sid_waveform_mixer

Overview:
Consumer end of the per-voice waveform generator output. It takes the waveform selector and the raw noise, pulse and sawtooth/triangle components, and combines them into the 12-bit waveform value that drives the voice DAC. It models the floating waveform output that persists when no waveform is selected, supplies the OSC3 readback byte, and returns noise LFSR writeback bits for combined waveforms. One instance sits between each voice's waveform generator and its DAC / envelope multiplier.

Parameters:
FLOAT_TTL_6581, 13'd182, ms a floating output is held on the MOS6581 before it reads as zero.
FLOAT_TTL_8580, 13'd4400, ms a floating output is held on the MOS8580 before it reads as zero.

Ports:
clk  in  1  system clock
res_n  in  1  asynchronous active-low reset
tick_ms  in  1  one-clk pulse, once per millisecond
model  in  1  0 = MOS6581, 1 = MOS8580
stb  in  1  one-clk strobe; inputs are valid and sampled on this cycle (once per SID cycle)
selector  in  4  {noise, pulse, sawtooth, triangle} enables
noise  in  8  noise LFSR tap bits, MSB first
pulse  in  1  pulse comparator output
saw_tri  in  12  sawtooth/triangle value
wav  out  12  combined waveform to DAC
wav_valid  out  1  one-clk pulse: wav updated this cycle
osc3  out  8  wav[11:4], for register 0x1B readback
noise_wb  out  8  LFSR writeback values (tap order as noise)
noise_wb_en  out  1  noise_wb is valid, so the LFSR taps are ANDed with noise_wb

Behaviour:
- Clock and reset: single clock clk; reset res_n is asynchronous and active-low. While res_n=0, every register clears: wav=0, wav_valid=0, osc3=0, noise_wb=8'hff, noise_wb_en=0, float_age=0, floating=0.
- All state updates only on clk edges where stb=1, except that wav_valid deasserts on the next clk.
- Component expansion:
  - N = {noise, 4'b0}
  - P = {12{pulse}}
  - S = saw_tri
  - Combined value C = bitwise AND of all selected components. The triangle and sawtooth bits both select S; S enters the AND once.
- When stb=1 and selector != 0:
  - wav <= C, osc3 <= C[11:4]
  - float_age <= 0, floating <= 0
- When stb=1 and selector == 0 (floating):
  - wav holds its previous value and floating <= 1.
  - float_age increments by tick_ms and saturates at 13'h1fff.
  - Let TTL = FLOAT_TTL_6581 when model=0, FLOAT_TTL_8580 when model=1. When float_age >= TTL, wav <= 0 and osc3 <= 0.
  - The >= comparison is required so a model change mid-hold takes effect immediately.
- A tick_ms pulse on a non-stb cycle is lost.
- Latency:
  - wav, osc3 and noise_wb update on the clk edge at which stb is sampled.
  - wav_valid=1 for exactly the following cycle.
  - Consecutive stb pulses produce consecutive updates. A stb on back-to-back cycles is legal, and wav_valid then stays high.
- Noise writeback:
  - noise_wb_en <= selector[3] & |selector[2:0] (registered on stb).
  - noise_wb <= C[11:4] when enabled, else 8'hff.
- Selector change from 0 to non-zero resets the age on that same stb. Re-entering floating restarts the count from 0.
- Reset mid-hold clears wav to 0 immediately (asynchronously).
- Mixer state FSM, derived from floating and from float_age against TTL:
  - ACTIVE -> HOLD on selector == 0.
  - HOLD -> FADED when age >= TTL.
  - HOLD/FADED -> ACTIVE on selector != 0.

Test Plan:
- Reset release, then stb with selector=4'b0010 and saw_tri=12'hABC -> next cycle wav=12'hABC, osc3=8'hAB, wav_valid=1 for one cycle, noise_wb_en=0.
- selector=4'b0110, pulse=1, saw_tri=12'h5A5 -> wav=12'h5A5. Then pulse=0 -> wav=12'h000.
- selector=4'b1010, noise=8'hF0, saw_tri=12'hCCC -> wav=12'hC00, osc3=8'hC0, noise_wb=8'hC0, noise_wb_en=1.
- model=0: wav=12'h800, then selector=0 with continuous stb and tick_ms -> wav stays 12'h800 through 181 ticks and becomes 0 after tick 182. Repeat with model=1 -> held until 4400 ticks.
- model=1 holding at age 500, switch to model=0 -> wav=0 on the next stb. Then selector=4'b0001, saw_tri=12'h123 -> wav=12'h123 and age cleared.
- Assert res_n=0 asynchronously mid-cycle during a hold -> wav, osc3 and wav_valid are 0 before the next clk edge. noise_wb=8'hff.
